decoder_n_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable.
- Successor to the 1-to-2 gate-level enable decoder.
- Adds a scan mode: an internal index register steps through the outputs one per enabled cycle and wraps at a programmable last index.
- Drives row/bank selects and time-multiplexed strobes; all outputs are registered so downstream logic sees glitch-free one-hot selects.

---
 rtl/decoder_n_seq.sv | 72 +++++++
 tb/tb_decoder_n_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N one-hot decoder with enable, plus a scan mode that steps an index and wraps at LAST.
// Latency 1 clk from sampled inputs to every output; no backpressure, a new input is accepted every cycle.
module decoder_n_seq #(
    parameter int N    = 3,
    parameter int LAST = 2**N - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e,
    input  logic              mode,
    input  logic [N-1:0]      in,
    input  logic              load,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int             W        = 2**N;
    localparam logic [N-1:0]   LAST_IDX = N'(LAST);

    logic [W-1:0] out_q, out_d;
    logic [N-1:0] idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         wrap_q, wrap_d;
    logic [N-1:0] nxt;
    logic         at_last;

    always_comb begin
        idx_d   = idx_q;
        out_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        nxt     = idx_q;
        // ">=" rather than "==" so an index carried over from decode mode beyond LAST wraps too
        at_last = (idx_q >= LAST_IDX);

        if (e) begin
            if (!mode) begin
                nxt = in;
            end else if (load) begin
                nxt = (in > LAST_IDX) ? LAST_IDX : in;
            end else begin
                nxt    = at_last ? '0 : idx_q + N'(1);
                wrap_d = at_last;
            end
            idx_d   = nxt;
            out_d   = W'(1) << nxt;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed bench for decoder_n_seq: expected outputs queued at drive time, popped one edge later.
module tb_decoder_n_seq;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       e, mode, load;
    logic [2:0] in;
    logic [7:0] out;
    logic [2:0] idx;
    logic       valid, wrap;

    logic       e2, mode2, load2;
    logic [1:0] in2;
    logic [3:0] out2;
    logic [1:0] idx2;
    logic       valid2, wrap2;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    decoder_n_seq #(.N(3), .LAST(5)) dut (
        .clk(clk), .reset(reset), .e(e), .mode(mode), .in(in), .load(load),
        .out(out), .idx(idx), .valid(valid), .wrap(wrap)
    );

    decoder_n_seq #(.N(2), .LAST(0)) dut2 (
        .clk(clk), .reset(reset), .e(e2), .mode(mode2), .in(in2), .load(load2),
        .out(out2), .idx(idx2), .valid(valid2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // sel=0 drives the N=3/LAST=5 instance, sel=1 the N=2/LAST=0 instance; the other idles
    task automatic step(input bit sel, input logic en, input logic md, input logic [2:0] sv,
                        input logic ld, input logic [7:0] eo, input logic [2:0] ei,
                        input logic ev, input logic ew, input string tag);
        exp_t got, expv;
        if (!sel) begin
            e = en; mode = md; in = sv; load = ld; e2 = 1'b0;
        end else begin
            e2 = en; mode2 = md; in2 = sv[1:0]; load2 = ld; e = 1'b0;
        end
        sb.push_back(exp_t'{eo, ei, ev, ew});
        @(posedge clk);
        #1;
        if (sel) got = exp_t'{{4'b0, out2}, {1'b0, idx2}, valid2, wrap2};
        else     got = exp_t'{out, idx, valid, wrap};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%0h expected=entry", tag, got);
        end else begin
            expv = sb.pop_front();
            chk({tag, ".out"},   got.out,          expv.out);
            chk({tag, ".idx"},   {5'b0, got.idx},  {5'b0, expv.idx});
            chk({tag, ".valid"}, {7'b0, got.valid}, {7'b0, expv.valid});
            chk({tag, ".wrap"},  {7'b0, got.wrap},  {7'b0, expv.wrap});
        end
    endtask

    // one-hot invariant on both instances, every cycle out of reset
    always @(negedge clk) begin
        logic [7:0] sel1;
        logic [3:0] sel2;
        if (!reset) begin
            sel1 = 8'd1 << idx;
            sel2 = 4'd1 << idx2;
            checks += 2;
            if (valid) begin
                assert (out === sel1 && $onehot(out)) else begin
                    errors++;
                    $error("FAIL inv1 observed=%0h expected=%0h", out, sel1);
                end
            end else begin
                assert (out === 8'h00) else begin
                    errors++;
                    $error("FAIL inv1_idle observed=%0h expected=0", out);
                end
            end
            if (valid2) begin
                assert (out2 === sel2 && $onehot(out2)) else begin
                    errors++;
                    $error("FAIL inv2 observed=%0h expected=%0h", out2, sel2);
                end
            end else begin
                assert (out2 === 4'h0) else begin
                    errors++;
                    $error("FAIL inv2_idle observed=%0h expected=0", out2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        e = 1'b0; mode = 1'b0; in = 3'd0; load = 1'b0;
        e2 = 1'b0; mode2 = 1'b0; in2 = 2'd0; load2 = 1'b0;
        #12;
        chk("rst.out",   out,            8'h00);
        chk("rst.idx",   {5'b0, idx},    8'h00);
        chk("rst.valid", {7'b0, valid},  8'h00);
        chk("rst.wrap",  {7'b0, wrap},   8'h00);
        reset = 1'b0;

        // 1: async reset mid-scan, then resume from 0
        step(0, 1, 1, 3'd4, 1, 8'h10, 3'd4, 1, 0, "t1_load4");
        #2 reset = 1'b1;
        #1;
        chk("t1_async.out",   out,           8'h00);
        chk("t1_async.idx",   {5'b0, idx},   8'h00);
        chk("t1_async.valid", {7'b0, valid}, 8'h00);
        #2 reset = 1'b0;
        step(0, 1, 1, 3'd0, 0, 8'h02, 3'd1, 1, 0, "t1_resume");

        // 2: decode sweep including indices above LAST, then disable
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 3'(i), 0, 8'd1 << i, 3'(i), 1, 0, "t2_dec");
        step(0, 1, 0, 3'd3, 1, 8'h08, 3'd3, 1, 0, "t2_dec_load_ignored");
        step(0, 1, 0, 3'd7, 0, 8'h80, 3'd7, 1, 0, "t2_dec7");
        step(0, 0, 0, 3'd2, 0, 8'h00, 3'd7, 0, 0, "t2_off");

        // 3: scan wrap at LAST
        step(0, 1, 1, 3'd4, 1, 8'h10, 3'd4, 1, 0, "t3_load4");
        step(0, 1, 1, 3'd0, 0, 8'h20, 3'd5, 1, 0, "t3_s5");
        step(0, 1, 1, 3'd0, 0, 8'h01, 3'd0, 1, 1, "t3_s0");
        step(0, 1, 1, 3'd0, 0, 8'h02, 3'd1, 1, 0, "t3_s1");

        // 4: load clamp, hold while disabled (load ignored), resume
        step(0, 1, 1, 3'd7, 1, 8'h20, 3'd5, 1, 0, "t4_clamp");
        step(0, 0, 1, 3'd1, 1, 8'h00, 3'd5, 0, 0, "t4_hold");
        step(0, 0, 1, 3'd1, 0, 8'h00, 3'd5, 0, 0, "t4_hold");
        step(0, 0, 0, 3'd2, 1, 8'h00, 3'd5, 0, 0, "t4_hold");
        step(0, 1, 1, 3'd0, 0, 8'h01, 3'd0, 1, 1, "t4_wrap");
        step(0, 1, 1, 3'd5, 1, 8'h20, 3'd5, 1, 0, "t4_load_last");
        step(0, 1, 1, 3'd0, 0, 8'h01, 3'd0, 1, 1, "t4_wrap2");

        // 5: decoded index above LAST carried into scan
        step(0, 1, 0, 3'd6, 0, 8'h40, 3'd6, 1, 0, "t5_dec6");
        step(0, 1, 1, 3'd0, 0, 8'h01, 3'd0, 1, 1, "t5_carry");
        step(0, 1, 1, 3'd0, 0, 8'h02, 3'd1, 1, 0, "t5_next");

        // 6: N=2, LAST=0 holds at 0 and wraps every step
        for (int i = 0; i < 4; i++)
            step(1, 1, 1, 3'd0, 0, 8'h01, 3'd0, 1, 1, "t6_last0");
        step(1, 1, 1, 3'd3, 1, 8'h01, 3'd0, 1, 0, "t6_clamp");

        e = 1'b0; e2 = 1'b0;
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
